// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage. It accepts a fetch strobe from the controller,
//   issues one word-aligned read to instruction memory, and captures the
//   returned word into the instruction register. The register is also
//   presented as decoded MIPS-style fields.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of WAIT cycles without an ack before the
//                    fetch is abandoned. It is only used when the timeout
//                    feature is built in.
//
// Build option
//   FETCH_TIMEOUT_EN : when defined, a fetch that gets no ack within
//                      TIMEOUT_CYCLES WAIT cycles is aborted. The unit then
//                      returns a NOP and sets the sticky fetch_err flag. When
//                      undefined, WAIT lasts until mem_ack and fetch_err is
//                      tied to 0.
//
// Ports
//   clk, reset           : clock (rising edge), asynchronous active-high reset
//   pc_in                : fetch address from the PC register
//   ir_write             : fetch strobe (IRWrite); ignored while a fetch is open
//   mem_req, mem_addr    : registered read request and word-aligned address
//   mem_ack, mem_rdata   : data-valid strobe and read data from memory
//   instr                : instruction register
//   opcode..imm16        : field slices of instr
//   ir_valid             : instr holds a completed fetch
//   fetch_busy           : combinational stall to the controller
//   misalign             : last accepted pc_in was not word aligned
//   fetch_count          : completed-fetch counter, wraps at 16 bits
//   fetch_err            : sticky timeout flag

module instr_fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        ir_write,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        misalign,
  output logic [15:0] fetch_count,
  output logic        fetch_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;

  // Only the word address is kept. The byte offset is reported through
  // misalign and never reaches the memory address.
  logic [31:2] pc_lat;

  logic accept;
  logic ack_take;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept   = (state == S_IDLE) && ir_write;
  // An ack counts only while a request is actually outstanding.
  assign ack_take = (state == S_WAIT) && mem_req && mem_ack;

  assign fetch_busy = (state == S_WAIT) || accept;
  assign mem_addr   = {pc_lat, 2'b00};

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

`ifdef FETCH_TIMEOUT_EN
  // The counter holds the number of WAIT cycles already spent without an
  // ack. The fetch aborts on the edge that would bring it to TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == S_WAIT) && mem_req && !mem_ack &&
                       (wait_cnt == CNT_LAST);
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_req     <= 1'b0;
      pc_lat      <= '0;
      instr       <= '0;
      ir_valid    <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ir_write) begin
            pc_lat   <= pc_in[31:2];
            misalign <= |pc_in[1:0];
            ir_valid <= 1'b0;
            mem_req  <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (ack_take) begin
            instr       <= mem_rdata;
            ir_valid    <= 1'b1;
            mem_req     <= 1'b0;
            fetch_count <= fetch_count + 16'd1;
            state       <= S_IDLE;
`ifdef FETCH_TIMEOUT_EN
          end else if (timeout_hit) begin
            // Hand the controller a NOP so it can continue, and flag the
            // failure without counting it as a completed fetch.
            instr     <= '0;
            ir_valid  <= 1'b1;
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum WAIT cycles before a fetch is aborted (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc_in  input  32  fetch address from the PC register.
REQ-005 SHALL have port ir_write  input  1  fetch strobe from the controller (IRWrite).
REQ-006 SHALL have port mem_req  output  1  instruction memory read request, registered.
REQ-007 SHALL have port mem_addr  output  32  word-aligned request address, {pc_lat[31:2],2'b00}.
REQ-008 SHALL have port mem_ack  input  1  memory data-valid strobe.
REQ-009 SHALL have port mem_rdata  input  32  memory read data.
REQ-010 SHALL have port instr  output  32  instruction register.
REQ-011 SHALL have ports opcode  output  6  instr[31:26]; funct  output  6  instr[5:0]; rs/rt/rd/shamt  output  5 each  instr[25:21]/[20:16]/[15:11]/[10:6]; imm16  output  16  instr[15:0].
REQ-012 SHALL have port ir_valid  output  1  instr holds a completed fetch.
REQ-013 SHALL have port fetch_busy  output  1  combinational stall to the controller.
REQ-014 SHALL have port misalign  output  1  last accepted pc_in had pc_in[1:0] != 0.
REQ-015 SHALL have port fetch_count  output  16  completed-fetch counter.
REQ-016 SHALL have port fetch_err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-018 IDLE with ir_write=1 SHALL latch pc_in into pc_lat, clear ir_valid, set misalign=|pc_in[1:0], set mem_req=1, and enter WAIT.
REQ-019 ir_write SHALL be ignored in WAIT; pc_in changes after acceptance SHALL NOT affect mem_addr.
REQ-020 mem_ack SHALL be sampled only when mem_req=1; in any other cycle it SHALL be ignored.
REQ-021 WAIT with mem_ack=1 SHALL load instr<=mem_rdata, set ir_valid=1, clear mem_req, increment fetch_count, and enter IDLE.
REQ-022 Minimum latency: ir_write in cycle N gives mem_req=1 in N+1; ack in N+1 gives instr/ir_valid valid in N+2.
REQ-023 fetch_busy SHALL equal (state==WAIT) | (state==IDLE & ir_write).
REQ-024 fetch_count SHALL wrap from 16'hFFFF to 0 without other side effect.
REQ-025 Field outputs SHALL be continuous slices of instr and change only when instr changes.
REQ-026 A misaligned fetch SHALL still be issued to the aligned address; misalign holds until the next accepted ir_write.

Reset
REQ-027 reset SHALL immediately force state=IDLE, mem_req=0, pc_lat=0, instr=0, ir_valid=0, misalign=0, fetch_count=0, fetch_err=0, and the wait counter to 0.
REQ-028 reset asserted in WAIT SHALL abandon the fetch; a mem_ack arriving after reset deassertion with mem_req=0 SHALL be ignored.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: a wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack; when it reaches TIMEOUT_CYCLES without ack, the unit SHALL clear mem_req, load instr=0 (NOP), set ir_valid=1, set fetch_err=1 (sticky until reset), leave fetch_count unchanged, and enter IDLE.
REQ-030 Macro FETCH_TIMEOUT_EN undefined: WAIT SHALL persist indefinitely until mem_ack, no wait counter SHALL exist, and fetch_err SHALL be tied to 0.

Verification
REQ-031 pc_in=0x00400004, ir_write pulse at cycle 0, ack at cycle 1 with rdata=0x012A4020 -> mem_addr=0x00400004, instr=0x012A4020 at cycle 2, opcode=0, rs=9, rt=10, rd=8, funct=0x20, fetch_count=1.
REQ-032 Ack delayed 5 cycles; pc_in changed and ir_write pulsed mid-WAIT -> mem_addr unchanged, fetch_busy=1 throughout, one fetch completes, fetch_count increments by 1.
REQ-033 pc_in=0x00000006 -> mem_addr=0x00000004, misalign=1; next fetch from 0x00000008 -> misalign=0.
REQ-034 Reset asserted 2 cycles into WAIT, ack arrives after release -> mem_req=0, instr=0, ir_valid=0, fetch_count=0.
REQ-035 fetch_count preset by 65535 completed fetches, one more fetch -> fetch_count=0.
REQ-036 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 WAIT cycles mem_req=0, instr=0, ir_valid=1, fetch_err=1; without macro, mem_req remains 1 after 100 cycles.
